regfile_p: RTL and testbench

REGFILE_P -- requirements
Module: regfile_p

---
 rtl/regfile_pkg.sv | 34 +++
 rtl/regfile_dump_fsm.sv | 71 +++++++
 rtl/regfile_p.sv | 113 +++++++++++
 tb/tb_regfile_p.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared definitions for the register file slice.
//   size_e       : operand size codes carried on the 'size' port
//   dump_state_e : register dump sequencer states
//   size_bytes() : byte count for a size code, capped at the register width
package regfile_pkg;

  typedef enum logic [1:0] {
    SZ_8    = 2'b00,
    SZ_16   = 2'b01,
    SZ_24   = 2'b10,
    SZ_FULL = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DUMP,
    ST_DONE
  } dump_state_e;

  // Size codes wider than the register collapse to full width.
  function automatic int unsigned size_bytes(input logic [1:0] size,
                                             input int unsigned dw_bytes);
    int unsigned n;
    case (size_e'(size))
      SZ_8:    n = 1;
      SZ_16:   n = 2;
      SZ_24:   n = 3;
      default: n = dw_bytes;
    endcase
    if (n > dw_bytes) n = dw_bytes;
    return n;
  endfunction

endpackage

// File: rtl/regfile_dump_fsm.sv
// Register dump sequencer: walks dump_sel over every register with a
// valid/ready handshake, then pulses done for one cycle.
//   clk, rst_n  : clock, asynchronous active-low reset
//   dump_start  : start request (only honoured when idle)
//   dump_ready  : consumer accepts the current word
//   reg_we      : register write request (dropped while busy)
//   dump_valid  : current word valid
//   dump_sel    : index of the register being presented
//   busy        : sequence active (writes blocked)
//   done        : one-cycle pulse after the last word is accepted
//   we_drop     : sticky, a write arrived while busy
module regfile_dump_fsm
  import regfile_pkg::*;
#(
  parameter int NREGS = 4,
  localparam int AW = $clog2(NREGS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          dump_start,
  input  logic          dump_ready,
  input  logic          reg_we,
  output logic          dump_valid,
  output logic [AW-1:0] dump_sel,
  output logic          busy,
  output logic          done,
  output logic          we_drop
);

  dump_state_e state, state_nxt;
  logic        last;

  assign last = (dump_sel == AW'(NREGS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (dump_start) state_nxt = ST_DUMP;
      ST_DUMP: if (dump_ready && last) state_nxt = ST_DONE;
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // dump_sel wraps back to zero after the last register since NREGS is a
  // power of two, so the next dump starts from a clean index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dump_sel <= '0;
      we_drop  <= 1'b0;
    end else begin
      if (state == ST_IDLE && dump_start) begin
        dump_sel <= '0;
        we_drop  <= 1'b0;
      end else if (state == ST_DUMP && dump_ready) begin
        dump_sel <= dump_sel + 1'b1;
      end
      if (state == ST_DUMP && reg_we) we_drop <= 1'b1;
    end
  end

  assign dump_valid = (state == ST_DUMP);
  assign busy       = (state == ST_DUMP);
  assign done       = (state == ST_DONE);

endmodule

// File: rtl/regfile_p.sv
// Register file with byte-sized partial writes, a stack pointer with
// wrap detection, and a handshaked register dump sequencer.
//   reg_we/reg_dst/dst/size : partial-width register write
//   reg_src/reg_idx -> src/idx : combinational reads (no write bypass)
//   txs/push/pull -> S, s_wrap : stack pointer load / decrement / increment
//   dump_* , busy, done, we_drop : register dump interface (sub-module)
module regfile_p
  import regfile_pkg::*;
#(
  parameter int          DW      = 24,
  parameter int          NREGS   = 4,
  parameter int          SW      = 16,
  parameter logic [SW-1:0] S_RESET = '1,
  localparam int         AW      = $clog2(NREGS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          reg_we,
  input  logic [AW-1:0] reg_dst,
  input  logic [AW-1:0] reg_src,
  input  logic [AW-1:0] reg_idx,
  input  logic [DW-1:0] dst,
  input  logic [1:0]    size,
  output logic [DW-1:0] src,
  output logic [DW-1:0] idx,
  output logic [SW-1:0] S,
  input  logic          txs,
  input  logic          push,
  input  logic          pull,
  output logic          s_wrap,
  input  logic          dump_start,
  output logic          dump_valid,
  input  logic          dump_ready,
  output logic [AW-1:0] dump_sel,
  output logic [DW-1:0] dump_data,
  output logic          busy,
  output logic          done,
  output logic          we_drop
);

  localparam int unsigned DWB = DW / 8;

  logic [DW-1:0] regs [NREGS];
  int unsigned   nbytes;
  logic [DW-1:0] wmask;
  logic [SW-1:0] n_ext;
  logic [SW-1:0] src_s;
  logic [SW:0]   s_dec;
  logic [SW:0]   s_inc;

  regfile_dump_fsm #(.NREGS(NREGS)) u_dump (
    .clk        (clk),
    .rst_n      (rst_n),
    .dump_start (dump_start),
    .dump_ready (dump_ready),
    .reg_we     (reg_we),
    .dump_valid (dump_valid),
    .dump_sel   (dump_sel),
    .busy       (busy),
    .done       (done),
    .we_drop    (we_drop)
  );

  always_comb begin
    nbytes = size_bytes(size, DWB);
    wmask  = '0;
    for (int unsigned b = 0; b < DWB; b++) begin
      if (b < nbytes) wmask[8*b +: 8] = '1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (reg_we && !busy) begin
      regs[reg_dst] <= (regs[reg_dst] & ~wmask) | (dst & wmask);
    end
  end

  assign src       = regs[reg_src];
  assign idx       = regs[reg_idx];
  assign dump_data = regs[dump_sel];

  generate
    if (SW <= DW) begin : g_src_trunc
      assign src_s = src[SW-1:0];
    end else begin : g_src_ext
      assign src_s = {{(SW-DW){1'b0}}, src};
    end
  endgenerate

  // The extra top bit of each result is the borrow/carry that marks a wrap.
  assign n_ext = SW'(nbytes);
  assign s_dec = {1'b0, S} - {1'b0, n_ext};
  assign s_inc = {1'b0, S} + {1'b0, n_ext};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      S      <= S_RESET;
      s_wrap <= 1'b0;
    end else if (txs) begin
      S      <= src_s;
      s_wrap <= 1'b0;
    end else if (push) begin
      S <= s_dec[SW-1:0];
      if (s_dec[SW]) s_wrap <= 1'b1;
    end else if (pull) begin
      S <= s_inc[SW-1:0];
      if (s_inc[SW]) s_wrap <= 1'b1;
    end
  end

endmodule

// File: tb/tb_regfile_p.sv
module tb_regfile_p;

  localparam int DW    = 24;
  localparam int NREGS = 4;
  localparam int SW    = 16;
  localparam int AW    = 2;
  localparam int DWB   = DW / 8;
  localparam int SMOD  = 1 << SW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          reg_we;
  logic [AW-1:0] reg_dst, reg_src, reg_idx;
  logic [DW-1:0] dst;
  logic [1:0]    size;
  logic [DW-1:0] src, idx;
  logic [SW-1:0] S;
  logic          txs, push, pull, s_wrap;
  logic          dump_start, dump_valid, dump_ready;
  logic [AW-1:0] dump_sel;
  logic [DW-1:0] dump_data;
  logic          busy, done, we_drop;

  always #5 clk = ~clk;

  regfile_p #(.DW(DW), .NREGS(NREGS), .SW(SW), .S_RESET(16'hFFFF)) dut (
    .clk(clk), .rst_n(rst_n), .reg_we(reg_we), .reg_dst(reg_dst),
    .reg_src(reg_src), .reg_idx(reg_idx), .dst(dst), .size(size),
    .src(src), .idx(idx), .S(S), .txs(txs), .push(push), .pull(pull),
    .s_wrap(s_wrap), .dump_start(dump_start), .dump_valid(dump_valid),
    .dump_ready(dump_ready), .dump_sel(dump_sel), .dump_data(dump_data),
    .busy(busy), .done(done), .we_drop(we_drop)
  );

  typedef struct {
    bit            rst;
    bit            we;
    logic [AW-1:0] dsel, ssel, isel;
    logic [DW-1:0] data;
    logic [1:0]    sz;
    bit            txs, push, pull, start, ready;
  } stim_t;

  typedef struct {
    logic [DW-1:0] src, idx;
    logic [SW-1:0] s;
    bit            wrap, valid, busy, done, drop;
    logic [AW-1:0] sel;
    logic [DW-1:0] data;
  } exp_t;

  typedef struct {
    logic [AW-1:0] sel;
    logic [DW-1:0] data;
  } word_t;

  exp_t  exp_q[$];
  word_t word_q[$];
  int    checks = 0;
  int    failures = 0;

  // Reference model state
  logic [DW-1:0] m_regs [NREGS];
  int            m_s;
  bit            m_wrap, m_dumping, m_done, m_drop;
  int            m_pos;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < NREGS; i++) m_regs[i] = '0;
    m_s = 16'hFFFF; m_wrap = 0; m_dumping = 0; m_done = 0; m_drop = 0; m_pos = 0;
  endfunction

  function automatic stim_t idle();
    stim_t st;
    st.rst = 0; st.we = 0; st.dsel = '0; st.ssel = '0; st.isel = '0;
    st.data = '0; st.sz = 2'b00; st.txs = 0; st.push = 0; st.pull = 0;
    st.start = 0; st.ready = 0;
    return st;
  endfunction

  function automatic stim_t wr(input int r, input logic [DW-1:0] v, input logic [1:0] sz);
    stim_t st = idle();
    st.we = 1; st.dsel = AW'(r); st.data = v; st.sz = sz;
    return st;
  endfunction

  task automatic step(input stim_t st);
    exp_t          e;
    int            n;
    longint        p;
    logic [DW-1:0] src_val;
    @(negedge clk);
    rst_n = !st.rst; reg_we = st.we; reg_dst = st.dsel; reg_src = st.ssel;
    reg_idx = st.isel; dst = st.data; size = st.sz; txs = st.txs;
    push = st.push; pull = st.pull; dump_start = st.start; dump_ready = st.ready;
    if (st.rst) begin
      model_reset();
      word_q.delete();
      e.src = '0; e.idx = '0; e.s = 16'hFFFF; e.wrap = 0; e.valid = 0;
      e.busy = 0; e.done = 0; e.drop = 0; e.sel = '0; e.data = '0;
      exp_q.push_back(e);
      return;
    end
    e.src = m_regs[st.ssel]; e.idx = m_regs[st.isel]; e.s = SW'(m_s);
    e.wrap = m_wrap; e.valid = m_dumping; e.busy = m_dumping; e.done = m_done;
    e.drop = m_drop; e.sel = AW'(m_pos); e.data = m_regs[m_pos];
    exp_q.push_back(e);

    n = (st.sz == 2'b11) ? DWB : int'(st.sz) + 1;
    if (n > DWB) n = DWB;
    src_val = m_regs[st.ssel];
    if (st.we) begin
      if (m_dumping) m_drop = 1;
      else begin
        p = longint'(1) << (8 * n);
        m_regs[st.dsel] = DW'((longint'(m_regs[st.dsel]) / p) * p + longint'(st.data) % p);
      end
    end
    if (st.txs) begin
      m_s = int'(src_val) % SMOD; m_wrap = 0;
    end else if (st.push) begin
      m_s = m_s - n;
      if (m_s < 0) begin m_s += SMOD; m_wrap = 1; end
    end else if (st.pull) begin
      m_s = m_s + n;
      if (m_s >= SMOD) begin m_s -= SMOD; m_wrap = 1; end
    end
    if (m_done) m_done = 0;
    else if (m_dumping) begin
      if (st.ready) begin
        if (m_pos == NREGS - 1) begin m_dumping = 0; m_done = 1; m_pos = 0; end
        else m_pos++;
      end
    end else if (st.start) begin
      m_dumping = 1; m_pos = 0; m_drop = 0;
      for (int i = 0; i < NREGS; i++) begin
        word_t w;
        w.sel = AW'(i); w.data = m_regs[i];
        word_q.push_back(w);
      end
    end
  endtask

  // Monitor: compares every cycle's outputs and each accepted dump word.
  initial begin
    exp_t  e;
    word_t w;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("src", src, e.src);
        chk("idx", idx, e.idx);
        chk("S", S, e.s);
        chk("s_wrap", s_wrap, e.wrap);
        chk("dump_valid", dump_valid, e.valid);
        chk("busy", busy, e.busy);
        chk("done", done, e.done);
        chk("we_drop", we_drop, e.drop);
        chk("dump_sel", dump_sel, e.sel);
        chk("dump_data", dump_data, e.data);
      end
      if (dump_valid === 1'b1 && dump_ready === 1'b1) begin
        if (word_q.size() == 0) chk("dump_word_unexpected", 1, 0);
        else begin
          w = word_q.pop_front();
          chk("dump_word_sel", dump_sel, w.sel);
          chk("dump_word_data", dump_data, w.data);
        end
      end
    end
  end

  initial begin
    stim_t st;
    rst_n = 1'b0; reg_we = 0; reg_dst = '0; reg_src = '0; reg_idx = '0;
    dst = '0; size = '0; txs = 0; push = 0; pull = 0; dump_start = 0; dump_ready = 0;
    model_reset();

    st = idle(); st.rst = 1;
    step(st); step(st);

    // Partial byte write preserves upper bytes
    step(wr(1, 24'h123456, 2'b11));
    step(wr(1, 24'h0000AB, 2'b00));
    st = idle(); st.ssel = 1; step(st);
    #3 chk("d_partial_write", src, 24'h1234AB);

    // Push borrow wraps, txs clears the flag
    step(wr(0, 24'h000001, 2'b11));
    st = idle(); st.txs = 1; st.ssel = 0; step(st);
    st = idle(); st.push = 1; st.sz = 2'b01; step(st);
    step(idle());
    #3 begin chk("d_push_wrap_S", S, 16'hFFFF); chk("d_push_wrap_flag", s_wrap, 1); end
    step(wr(3, 24'h0001FF, 2'b11));
    st = idle(); st.txs = 1; st.ssel = 3; step(st);
    step(idle());
    #3 begin chk("d_txs_S", S, 16'h01FF); chk("d_txs_clear", s_wrap, 0); end

    // txs wins over push and pull
    step(wr(2, 24'h004000, 2'b11));
    st = idle(); st.txs = 1; st.push = 1; st.pull = 1; st.ssel = 2; step(st);
    step(idle());
    #3 chk("d_txs_priority", S, 16'h4000);

    // Dump with toggled ready
    for (int i = 0; i < NREGS; i++) step(wr(i, DW'(i), 2'b11));
    st = idle(); st.start = 1; step(st);
    for (int k = 0; k < 20; k++) begin
      st = idle(); st.ready = (k % 2 == 0); step(st);
    end
    #3 begin chk("d_dump_busy_after", busy, 0); chk("d_dump_words_left", word_q.size(), 0); end

    // Write during dump is dropped; next start clears we_drop
    st = idle(); st.start = 1; step(st);
    st = wr(2, 24'hFFFFFF, 2'b11); step(st);
    st = idle(); st.ssel = 2; step(st);
    #3 begin chk("d_we_drop_set", we_drop, 1); chk("d_we_dropped_reg", src, 24'h000002); end
    for (int k = 0; k < 8; k++) begin st = idle(); st.ready = 1; step(st); end
    st = idle(); st.start = 1; step(st);
    step(idle());
    #3 chk("d_we_drop_clear", we_drop, 0);
    for (int k = 0; k < 8; k++) begin st = idle(); st.ready = 1; step(st); end

    // Reset in the middle of a dump
    st = idle(); st.start = 1; step(st);
    st = idle(); st.ready = 1; step(st); step(st);
    step(idle());
    #3 chk("d_mid_dump_sel", dump_sel, 2);
    st = idle(); st.rst = 1; step(st);
    #3 begin
      chk("d_rst_busy", busy, 0); chk("d_rst_valid", dump_valid, 0);
      chk("d_rst_S", S, 16'hFFFF); chk("d_rst_src", src, 0);
    end
    step(idle()); step(idle());
    #3 chk("d_rst_no_done", done, 0);

    // Randomized traffic
    for (int k = 0; k < 1500; k++) begin
      st.rst   = ($urandom_range(0, 199) == 0);
      st.we    = $urandom_range(0, 1);
      st.dsel  = AW'($urandom_range(0, NREGS - 1));
      st.ssel  = AW'($urandom_range(0, NREGS - 1));
      st.isel  = AW'($urandom_range(0, NREGS - 1));
      st.data  = DW'($urandom);
      st.sz    = 2'($urandom_range(0, 3));
      st.txs   = ($urandom_range(0, 19) == 0);
      st.push  = ($urandom_range(0, 4) == 0);
      st.pull  = ($urandom_range(0, 4) == 0);
      st.start = ($urandom_range(0, 24) == 0);
      st.ready = $urandom_range(0, 1);
      step(st);
    end
    for (int k = 0; k < 12; k++) begin st = idle(); st.ready = 1; step(st); end
    step(idle());
    #3 begin
      chk("end_words_left", word_q.size(), 0);
      chk("end_busy", busy, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
